// File: rtl/num_entry.sv
// ---------------------------------------------------------------------------
// num_entry
// Keypad number-entry front end for a BCD adder. Digits are typed into an
// entry register, 0xA latches the first operand, 0xD latches the second
// operand and offers both to the downstream adder with a valid/ready
// handshake. After the transfer the block holds the result operands until
// the user clears or starts typing a new number.
//
// Ports
//   i_clk        system clock, rising edge
//   i_n_reset    asynchronous active-low reset
//   i_key_valid  one-cycle strobe per debounced key press
//   i_key_code   key identity (0-9 digit, A add, C clear, D enter)
//   o_op_a       first operand, packed BCD, MS digit in top nibble
//   o_op_b       second operand, packed BCD
//   o_op_valid   operands offered to the adder (high exactly in SEND)
//   i_op_ready   adder accepts the operands
//   o_disp_bcd   digits for the display decoder
//   o_ovf        sticky flag: a digit was dropped because entry was full
//   o_state_dbg  current FSM state encoding for debug LEDs
// ---------------------------------------------------------------------------
module num_entry #(
  parameter int NDIG = 3
) (
  input  logic              i_clk,
  input  logic              i_n_reset,
  input  logic              i_key_valid,
  input  logic [3:0]        i_key_code,
  output logic [4*NDIG-1:0] o_op_a,
  output logic [4*NDIG-1:0] o_op_b,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic [4*NDIG-1:0] o_disp_bcd,
  output logic              o_ovf,
  output logic [1:0]        o_state_dbg
);

  localparam int W  = 4 * NDIG;
  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    SEND    = 2'b10,
    HOLD    = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [W-1:0]  r_entry;
  logic [W-1:0]  w_entryNext;
  logic [W-1:0]  r_opA;
  logic [W-1:0]  w_opANext;
  logic [W-1:0]  r_opB;
  logic [W-1:0]  w_opBNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic          r_ovf;
  logic          w_ovfNext;
  logic          r_opValid;

  logic          w_isDigit;
  logic          w_isAdd;
  logic          w_isClear;
  logic          w_isEnter;
  logic          w_keyNonZero;
  logic [W-1:0]  w_keyExt;
  logic [W+3:0]  w_shiftWide;
  logic [W-1:0]  w_shifted;

  // Key decode; every strobe is qualified by i_key_valid so key_code is
  // don't-care between presses.
  assign w_isDigit    = i_key_valid && (i_key_code <= 4'd9);
  assign w_isAdd      = i_key_valid && (i_key_code == 4'hA);
  assign w_isClear    = i_key_valid && (i_key_code == 4'hC);
  assign w_isEnter    = i_key_valid && (i_key_code == 4'hD);
  assign w_keyNonZero = (i_key_code != 4'h0);
  assign w_keyExt     = W'(i_key_code);

  // Shift-in goes through a wider vector so the slice stays legal even
  // when NDIG=1 (the shift path is unreachable there, but must elaborate).
  assign w_shiftWide  = {r_entry, i_key_code};
  assign w_shifted    = w_shiftWide[W-1:0];

  // Next-state and datapath decisions. Everything defaults to holding its
  // value; SEND ignores all keys so the offered operands cannot move while
  // op_valid is high.
  always_comb begin
    w_stateNext = r_state;
    w_entryNext = r_entry;
    w_cntNext   = r_cnt;
    w_opANext   = r_opA;
    w_opBNext   = r_opB;
    w_ovfNext   = r_ovf;

    case (r_state)
      ENTER_A, ENTER_B: begin
        if (w_isDigit) begin
          if (r_cnt == CNT_MAX) begin
            w_ovfNext = 1'b1;
          end else if (r_cnt == '0) begin
            // Leading zeros are swallowed so the count reflects real digits.
            if (w_keyNonZero) begin
              w_entryNext = w_keyExt;
              w_cntNext   = CW'(1);
            end
          end else begin
            w_entryNext = w_shifted;
            w_cntNext   = r_cnt + CW'(1);
          end
        end else if (w_isClear) begin
          w_entryNext = '0;
          w_cntNext   = '0;
          w_opANext   = '0;
          w_opBNext   = '0;
          w_ovfNext   = 1'b0;
          w_stateNext = ENTER_A;
        end else if (w_isAdd && (r_state == ENTER_A)) begin
          w_opANext   = r_entry;
          w_entryNext = '0;
          w_cntNext   = '0;
          w_stateNext = ENTER_B;
        end else if (w_isEnter && (r_state == ENTER_B)) begin
          w_opBNext   = r_entry;
          w_stateNext = SEND;
        end
      end

      SEND: begin
        if (i_op_ready) begin
          w_stateNext = HOLD;
        end
      end

      HOLD: begin
        if (w_isClear) begin
          w_entryNext = '0;
          w_cntNext   = '0;
          w_opANext   = '0;
          w_opBNext   = '0;
          w_ovfNext   = 1'b0;
          w_stateNext = ENTER_A;
        end else if (w_isDigit) begin
          // A digit here starts a fresh calculation immediately, so the
          // entry restarts from empty rather than from the stale operand.
          w_opANext   = '0;
          w_opBNext   = '0;
          w_ovfNext   = 1'b0;
          w_entryNext = w_keyNonZero ? w_keyExt : '0;
          w_cntNext   = w_keyNonZero ? CW'(1) : '0;
          w_stateNext = ENTER_A;
        end
      end

      default: begin
        w_stateNext = ENTER_A;
      end
    endcase
  end

  // State and datapath registers. op_valid is registered from the next
  // state so it is high exactly while the FSM sits in SEND, and the async
  // reset drops it without waiting for a clock edge.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state   <= ENTER_A;
      r_entry   <= '0;
      r_cnt     <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_ovf     <= 1'b0;
      r_opValid <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_entry   <= w_entryNext;
      r_cnt     <= w_cntNext;
      r_opA     <= w_opANext;
      r_opB     <= w_opBNext;
      r_ovf     <= w_ovfNext;
      r_opValid <= (w_stateNext == SEND);
    end
  end

  // Display follows the digits being typed, then shows the second operand
  // once it has been committed.
  always_comb begin
    o_disp_bcd = r_entry;
    if ((r_state == SEND) || (r_state == HOLD)) begin
      o_disp_bcd = r_opB;
    end
  end

  assign o_op_a      = r_opA;
  assign o_op_b      = r_opB;
  assign o_op_valid  = r_opValid;
  assign o_ovf       = r_ovf;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_num_entry.sv
// ---------------------------------------------------------------------------
// tb_num_entry
// Self-checking bench for num_entry (NDIG=3). Expected operand pairs are
// pushed to a scoreboard queue when 0xD is pressed and popped by a monitor
// when the handshake completes; scenario tasks check state, display and
// flags inline.
// ---------------------------------------------------------------------------
module tb_num_entry;

  logic        clk;
  logic        n_reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] op_a;
  logic [11:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic [11:0] disp_bcd;
  logic        ovf;
  logic [1:0]  state_dbg;

  int          vectors;
  int          miscompares;
  int          validCycles;
  logic [23:0] sbQ[$];
  logic [23:0] sbExp;

  num_entry #(.NDIG(3)) dut (
    .i_clk       (clk),
    .i_n_reset   (n_reset),
    .i_key_valid (key_valid),
    .i_key_code  (key_code),
    .o_op_a      (op_a),
    .o_op_b      (op_b),
    .o_op_valid  (op_valid),
    .i_op_ready  (op_ready),
    .o_disp_bcd  (disp_bcd),
    .o_ovf       (ovf),
    .o_state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer monitor: a handshake seen at the falling edge completes on the
  // next rising edge, so the offered operands are compared against the
  // scoreboard here.
  always @(negedge clk) begin
    if (op_valid) validCycles++;
    if (op_valid && op_ready) begin
      vectors++;
      if (sbQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL transfer: unexpected transfer op_a=%h op_b=%h, none expected", op_a, op_b);
      end else begin
        sbExp = sbQ.pop_front();
        if ({op_a, op_b} !== sbExp) begin
          miscompares++;
          $display("[TB] FAIL transfer: got op_a=%h op_b=%h want op_a=%h op_b=%h",
                   op_a, op_b, sbExp[23:12], sbExp[11:0]);
        end
      end
    end
  end

  // One key press: strobe is driven just after a rising edge and sampled on
  // the next one; returns 1 time unit after the sampling edge.
  task automatic pressKey(input logic [3:0] k);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    #2;
    vectors++;
    if ({state_dbg, op_valid, ovf, op_a, op_b, disp_bcd} !== 40'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got state=%b valid=%b ovf=%b a=%h b=%h disp=%h want all zero",
               state_dbg, op_valid, ovf, op_a, op_b, disp_bcd);
    end
    #10;
    n_reset = 1'b1;
  endtask

  task automatic test_basic;
    op_ready = 1'b1;
    pressKey(4'h1);
    vectors++;
    if (disp_bcd !== 12'h001 || state_dbg !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL first_key: got disp=%h state=%b want disp=001 state=00", disp_bcd, state_dbg);
    end
    pressKey(4'h2);
    pressKey(4'h3);
    vectors++;
    if (disp_bcd !== 12'h123) begin
      miscompares++;
      $display("[TB] FAIL entry_123: got %h want 123", disp_bcd);
    end
    pressKey(4'hA);
    vectors++;
    if (state_dbg !== 2'b01 || op_a !== 12'h123 || disp_bcd !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL add_key: got state=%b op_a=%h disp=%h want 01 123 000", state_dbg, op_a, disp_bcd);
    end
    pressKey(4'h4);
    pressKey(4'h5);
    vectors++;
    if (disp_bcd !== 12'h045) begin
      miscompares++;
      $display("[TB] FAIL entry_045: got %h want 045", disp_bcd);
    end
    sbQ.push_back({12'h123, 12'h045});
    pressKey(4'hD);
    vectors++;
    if (state_dbg !== 2'b10 || op_valid !== 1'b1 || disp_bcd !== 12'h045) begin
      miscompares++;
      $display("[TB] FAIL send_entry: got state=%b valid=%b disp=%h want 10 1 045", state_dbg, op_valid, disp_bcd);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (state_dbg !== 2'b11 || op_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_entry: got state=%b valid=%b want 11 0", state_dbg, op_valid);
    end
    pressKey(4'hC);
    vectors++;
    if ({state_dbg, op_a, op_b, disp_bcd} !== 38'd0) begin
      miscompares++;
      $display("[TB] FAIL clear_hold: got state=%b a=%h b=%h disp=%h want all zero", state_dbg, op_a, op_b, disp_bcd);
    end
  endtask

  task automatic test_overflow;
    pressKey(4'h0);
    pressKey(4'h0);
    vectors++;
    if (disp_bcd !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL leading_zero: got %h want 000", disp_bcd);
    end
    pressKey(4'h7);
    pressKey(4'h8);
    pressKey(4'h9);
    vectors++;
    if (disp_bcd !== 12'h789 || ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_entry: got disp=%h ovf=%b want 789 0", disp_bcd, ovf);
    end
    pressKey(4'h5);
    vectors++;
    if (disp_bcd !== 12'h789 || ovf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow: got disp=%h ovf=%b want 789 1", disp_bcd, ovf);
    end
    pressKey(4'hC);
    vectors++;
    if (disp_bcd !== 12'h000 || ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_ovf: got disp=%h ovf=%b want 000 0", disp_bcd, ovf);
    end
  endtask

  task automatic test_backpressure;
    op_ready = 1'b0;
    pressKey(4'h9);
    pressKey(4'hA);
    pressKey(4'h9);
    sbQ.push_back({12'h009, 12'h009});
    validCycles = 0;
    pressKey(4'hD);
    pressKey(4'hC);
    pressKey(4'h5);
    vectors++;
    if (state_dbg !== 2'b10 || op_a !== 12'h009 || op_b !== 12'h009 || disp_bcd !== 12'h009) begin
      miscompares++;
      $display("[TB] FAIL send_stall: got state=%b a=%h b=%h disp=%h want 10 009 009 009",
               state_dbg, op_a, op_b, disp_bcd);
    end
    @(posedge clk);
    #1;
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (state_dbg !== 2'b11 || op_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got state=%b valid=%b want 11 0", state_dbg, op_valid);
    end
    vectors++;
    if (validCycles !== 6) begin
      miscompares++;
      $display("[TB] FAIL valid_width: got %0d cycles want 6", validCycles);
    end
  endtask

  task automatic test_hold_digit;
    pressKey(4'hC);
    pressKey(4'h1);
    pressKey(4'hA);
    pressKey(4'h2);
    pressKey(4'h3);
    pressKey(4'h4);
    pressKey(4'h5);
    sbQ.push_back({12'h001, 12'h234});
    pressKey(4'hD);
    @(posedge clk);
    #1;
    vectors++;
    if (state_dbg !== 2'b11 || ovf !== 1'b1 || disp_bcd !== 12'h234) begin
      miscompares++;
      $display("[TB] FAIL hold_sticky: got state=%b ovf=%b disp=%h want 11 1 234", state_dbg, ovf, disp_bcd);
    end
    pressKey(4'h6);
    vectors++;
    if (state_dbg !== 2'b00 || disp_bcd !== 12'h006 || op_a !== 12'h000 || op_b !== 12'h000 || ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_digit: got state=%b disp=%h a=%h b=%h ovf=%b want 00 006 000 000 0",
               state_dbg, disp_bcd, op_a, op_b, ovf);
    end
  endtask

  task automatic test_reset_in_send;
    pressKey(4'hC);
    op_ready = 1'b0;
    pressKey(4'h7);
    pressKey(4'hA);
    pressKey(4'h8);
    sbQ.push_back({12'h007, 12'h008});
    pressKey(4'hD);
    vectors++;
    if (op_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_send: got valid=%b want 1", op_valid);
    end
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    vectors++;
    if ({state_dbg, op_valid, ovf, op_a, op_b, disp_bcd} !== 40'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got state=%b valid=%b ovf=%b a=%h b=%h disp=%h want all zero",
               state_dbg, op_valid, ovf, op_a, op_b, disp_bcd);
    end
    n_reset = 1'b1;
    if (sbQ.size() > 0) void'(sbQ.pop_back());
    op_ready = 1'b1;
    pressKey(4'h3);
    vectors++;
    if (disp_bcd !== 12'h003) begin
      miscompares++;
      $display("[TB] FAIL post_reset_key: got %h want 003", disp_bcd);
    end
    pressKey(4'hA);
    pressKey(4'h4);
    sbQ.push_back({12'h003, 12'h004});
    pressKey(4'hD);
    @(posedge clk);
    #1;
    vectors++;
    if (state_dbg !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL post_reset_hold: got state=%b want 11", state_dbg);
    end
  endtask

  task automatic test_ignored_keys;
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    #2;
    n_reset = 1'b1;
    key_code = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (disp_bcd !== 12'h000 || state_dbg !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL no_strobe: got disp=%h state=%b want 000 00", disp_bcd, state_dbg);
    end
    pressKey(4'hD);
    vectors++;
    if (state_dbg !== 2'b00 || op_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL enter_in_a: got state=%b valid=%b want 00 0", state_dbg, op_valid);
    end
    pressKey(4'hA);
    vectors++;
    if (state_dbg !== 2'b01 || op_a !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL add_empty: got state=%b op_a=%h want 01 000", state_dbg, op_a);
    end
    pressKey(4'hA);
    pressKey(4'hB);
    pressKey(4'hE);
    pressKey(4'hF);
    vectors++;
    if (state_dbg !== 2'b01 || disp_bcd !== 12'h000 || op_a !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL unused_keys: got state=%b disp=%h op_a=%h want 01 000 000", state_dbg, disp_bcd, op_a);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    validCycles = 0;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    op_ready    = 1'b1;
    n_reset     = 1'b0;

    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_hold_digit();
    test_reset_in_send();
    test_ignored_keys();

    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (sbQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
